// File: rtl/pwm_multi_if.sv
// Offer channel for pwm_multi: a new half-period and per-channel duties,
// accepted by the PWM core when its shadow buffer is empty.
interface pwm_multi_if #(
  parameter int D_WIDTH = 16,
  parameter int N_CH    = 3
);
  logic                      valid;
  logic                      ready;
  logic [D_WIDTH-1:0]        period_top;
  logic [N_CH*D_WIDTH-1:0]   duty_in;

  // Producer of new settings.
  modport master (output valid, period_top, duty_in, input ready);
  // PWM core consuming the settings.
  modport slave  (input valid, period_top, duty_in, output ready);
endinterface

// File: rtl/pwm_multi.sv
// Multi-channel centre-aligned (up/down) PWM with complementary outputs,
// per-channel dead time and a one-deep shadow buffer for period/duty updates
// that are applied only at the counter valley.
module pwm_multi #(
  parameter int D_WIDTH  = 16,
  parameter int N_CH     = 3,
  parameter int DT_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [DT_WIDTH-1:0] deadtime,
  pwm_multi_if.slave          bus,
  output logic [N_CH-1:0]     pwm_hi,
  output logic [N_CH-1:0]     pwm_lo,
  output logic                period_start
);

  typedef enum logic [1:0] {S_IDLE, S_UP, S_DOWN} state_e;

  state_e                    state_q;
  logic [D_WIDTH-1:0]        cnt_q;
  logic [D_WIDTH-1:0]        act_p_q, pend_p_q;
  logic [N_CH*D_WIDTH-1:0]   act_duty_q, pend_duty_q;
  logic                      pend_q;
  logic [N_CH-1:0]           raw, raw_q;
  logic                      run_q;
  logic [DT_WIDTH-1:0]       dt_q [N_CH];

  logic                      valley;
  logic                      load;
  logic                      capture;
  logic [D_WIDTH-1:0]        p_eff;

  assign valley       = (state_q == S_UP) && (cnt_q == '0);
  assign period_start = valley;
  assign bus.ready    = ~pend_q;
  assign capture      = bus.valid && !pend_q;
  // Pending settings move to active at a valley, or straight away when idle.
  assign load         = en && pend_q && ((state_q == S_IDLE) || valley);
  // Period governing this edge's transition: the one being loaded, if any.
  assign p_eff        = load ? pend_p_q : act_p_q;

  // Shadow buffer: capture offers while empty, hand over to active on load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: these are a handful of flops, not a RAM, so they are reset;
      // a cleared active period keeps the counter idle until a real capture.
      pend_q      <= 1'b0;
      pend_p_q    <= '0;
      pend_duty_q <= '0;
      act_p_q     <= '0;
      act_duty_q  <= '0;
    end else if (load) begin
      act_p_q    <= pend_p_q;
      act_duty_q <= pend_duty_q;
      pend_q     <= 1'b0;
    end else if (capture) begin
      pend_p_q    <= bus.period_top;
      pend_duty_q <= bus.duty_in;
      pend_q      <= 1'b1;
    end
  end

  // Up/down counter FSM: 0..P-1 counting up, P..1 counting down.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else if (!en) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (p_eff != '0) state_q <= S_UP;
        end
        S_UP: begin
          if (valley && (p_eff == '0)) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + D_WIDTH'(1);
            if (cnt_q == p_eff - D_WIDTH'(1)) state_q <= S_DOWN;
          end
        end
        S_DOWN: begin
          cnt_q <= cnt_q - D_WIDTH'(1);
          if (cnt_q == D_WIDTH'(1)) state_q <= S_UP;
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Raw compare per channel; inclusive on the way down keeps the pulse symmetric.
  always_comb begin
    // NOTE: default first so no path leaves raw unassigned (no latch).
    raw = '0;
    for (int i = 0; i < N_CH; i++) begin
      case (state_q)
        S_UP:    raw[i] = cnt_q <  act_duty_q[i*D_WIDTH +: D_WIDTH];
        S_DOWN:  raw[i] = cnt_q <= act_duty_q[i*D_WIDTH +: D_WIDTH];
        default: raw[i] = 1'b0;
      endcase
    end
  end

  // Register raw compare and run dead-time counters, restarting on every edge of raw_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst || !en) begin
      raw_q <= '0;
      run_q <= 1'b0;
      for (int i = 0; i < N_CH; i++) dt_q[i] <= '0;
    end else begin
      raw_q <= raw;
      run_q <= (state_q != S_IDLE);
      for (int i = 0; i < N_CH; i++) begin
        if (raw[i] != raw_q[i])  dt_q[i] <= deadtime;
        else if (dt_q[i] != '0)  dt_q[i] <= dt_q[i] - DT_WIDTH'(1);
      end
    end
  end

  // Gate drive: both sides off while idle or while a dead-time count is running.
  always_comb begin
    pwm_hi = '0;
    pwm_lo = '0;
    for (int i = 0; i < N_CH; i++) begin
      pwm_hi[i] = run_q && (dt_q[i] == '0) &&  raw_q[i];
      pwm_lo[i] = run_q && (dt_q[i] == '0) && !raw_q[i];
    end
  end

endmodule

// File: tb/tb_pwm_multi.sv
// Scoreboard bench for pwm_multi: a phase-based reference model predicts
// every cycle's outputs; a monitor pops and compares on the falling edge.
module tb_pwm_multi;
  localparam int DW = 16;
  localparam int NC = 3;
  localparam int TW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [TW-1:0] deadtime;
  logic [NC-1:0] pwm_hi, pwm_lo;
  logic          period_start;

  pwm_multi_if #(.D_WIDTH(DW), .N_CH(NC)) bus ();

  pwm_multi #(.D_WIDTH(DW), .N_CH(NC), .DT_WIDTH(TW)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .deadtime     (deadtime),
    .bus          (bus.slave),
    .pwm_hi       (pwm_hi),
    .pwm_lo       (pwm_lo),
    .period_start (period_start)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          ps;
    logic          rdy;
    logic [NC-1:0] hi;
    logic [NC-1:0] lo;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver-side stimulus values for the next edge.
  bit drv_en, drv_valid;
  int drv_p, drv_dt;
  int drv_d[NC];

  // Reference model: position t within a 2P-cycle period instead of a counter.
  bit            m_idle;
  int            m_t, m_p, m_pp, m_D;
  int            m_duty[NC];
  int            m_pd[NC];
  bit            m_pend, m_runq;
  bit [NC-1:0]   m_rawq;
  bit [NC-1:0]   m_hist[$];   // raw_q history, newest at back

  function automatic bit [NC-1:0] model_raw();
    bit [NC-1:0] r = '0;
    if (!m_idle)
      for (int c = 0; c < NC; c++)
        r[c] = (m_t < m_p) ? (m_t < m_duty[c]) : ((2*m_p - m_t) <= m_duty[c]);
    return r;
  endfunction

  // Outputs drive once raw_q has held its value for deadtime+1 cycles.
  function automatic exp_t model_expect();
    exp_t e;
    e.ps  = !m_idle && (m_t == 0);
    e.rdy = !m_pend;
    e.hi  = '0;
    e.lo  = '0;
    for (int c = 0; c < NC; c++) begin
      bit stable = 1'b1;
      for (int j = 1; j <= m_D; j++) begin
        int idx = m_hist.size() - 1 - j;
        bit v   = (idx >= 0) ? m_hist[idx][c] : 1'b0;
        if (v != m_rawq[c]) stable = 1'b0;
      end
      e.hi[c] = m_runq && stable &&  m_rawq[c];
      e.lo[c] = m_runq && stable && !m_rawq[c];
    end
    return e;
  endfunction

  task automatic model_reset();
    m_idle = 1; m_t = 0; m_p = 0; m_pp = 0; m_pend = 0;
    m_runq = 0; m_rawq = '0; m_D = drv_dt;
    for (int c = 0; c < NC; c++) begin m_duty[c] = 0; m_pd[c] = 0; end
    m_hist.delete(); m_hist.push_back('0);
  endtask

  task automatic model_load();
    m_p = m_pp;
    for (int c = 0; c < NC; c++) m_duty[c] = m_pd[c];
    m_pend = 0;
  endtask

  task automatic model_advance();
    bit [NC-1:0] r = model_raw();
    bit old_pend   = m_pend;
    if (!drv_en) begin
      m_rawq = '0; m_runq = 0; m_D = drv_dt;
      m_hist.delete(); m_hist.push_back('0);
      m_idle = 1; m_t = 0;
    end else begin
      m_rawq = r; m_runq = !m_idle;
      m_hist.push_back(r);
      if (m_hist.size() > 32) void'(m_hist.pop_front());
      if (m_idle) begin
        if (m_pend) model_load();
        if (m_p > 0) begin m_idle = 0; m_t = 0; end
      end else begin
        if (m_t == 0 && m_pend) model_load();
        if (m_p == 0) begin m_idle = 1; m_t = 0; end
        else m_t = (m_t + 1) % (2*m_p);
      end
    end
    if (drv_valid && !old_pend) begin
      m_pp = drv_p;
      for (int c = 0; c < NC; c++) m_pd[c] = drv_d[c];
      m_pend = 1;
    end
  endtask

  task automatic drive();
    en             = drv_en;
    bus.valid      = drv_valid;
    bus.period_top = DW'(drv_p);
    for (int c = 0; c < NC; c++) bus.duty_in[c*DW +: DW] = DW'(drv_d[c]);
    deadtime       = TW'(drv_dt);
  endtask

  // One clock: queue this cycle's expectation, then apply next inputs.
  task automatic step();
    @(posedge clk); #1;
    sb_q.push_back(model_expect());
    drive();
    model_advance();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_cfg(input int p, input int d0, input int d1, input int d2);
    drv_p = p; drv_d[0] = d0; drv_d[1] = d1; drv_d[2] = d2;
  endtask

  // Count channel-0 high/low cycles over one full period starting at a valley.
  task automatic measure(input string nm, input int exp_hi, input int exp_lo);
    int k = 0, nh = 0, nl = 0;
    while (!period_start && k < 40) begin step(); k++; end
    check({nm, "_valley_seen"}, 32'(k < 40), 1);
    for (int i = 0; i < 16; i++) begin
      nh += int'(pwm_hi[0]);
      nl += int'(pwm_lo[0]);
      step();
    end
    check({nm, "_hi_cycles"}, nh, exp_hi);
    check({nm, "_lo_cycles"}, nl, exp_lo);
  endtask

  // Monitor: one expectation per cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("period_start", period_start, e.ps);
        check("ready", bus.ready, e.rdy);
        check("pwm_hi", pwm_hi, e.hi);
        check("pwm_lo", pwm_lo, e.lo);
        check("no_shoot_through", pwm_hi & pwm_lo, 0);
      end
    end
  end

  initial begin
    int k, drop_left;
    drv_en = 0; drv_valid = 0; drv_dt = 0; set_cfg(0, 0, 0, 0);
    rst = 1'b1;
    drive();
    #3;
    check("reset_hi", pwm_hi, 0);
    check("reset_lo", pwm_lo, 0);
    check("reset_ready", bus.ready, 1);
    check("reset_period_start", period_start, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    model_advance();
    steps(3);

    // P=8, duty0=4, no dead time; ch1 duty 0, ch2 duty 8
    drv_en = 1; drv_valid = 1; set_cfg(8, 4, 0, 8);
    step();
    drv_valid = 0;
    steps(40);
    measure("dt0", 8, 8);

    // Same with dead time 2, changed while disabled, then restart
    drv_en = 0; drv_dt = 2;
    steps(3);
    drv_en = 1;
    steps(40);
    measure("dt2", 6, 6);

    // Duty above P, zero, and equal to P
    drv_valid = 1; set_cfg(8, 20, 0, 8);
    step();
    drv_valid = 0;
    steps(40);
    check("const_hi", pwm_hi, 3'b101);
    check("const_lo", pwm_lo, 3'b010);

    // Capture at UP cnt=5, then a second offer while ready is low
    k = 0;
    while (!(!m_idle && m_t == 5) && k < 100) begin step(); k++; end
    drv_valid = 1; set_cfg(8, 2, 0, 8);
    step();
    set_cfg(8, 6, 3, 1);
    step();
    check("ready_low_after_capture", bus.ready, 0);
    drv_valid = 0;
    steps(40);

    // Asynchronous reset mid-DOWN with a gate driven high
    k = 0;
    while (!(!m_idle && m_t > m_p && model_expect().hi != 0) && k < 100) begin step(); k++; end
    step();
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    check("async_rst_hi", pwm_hi, 0);
    check("async_rst_lo", pwm_lo, 0);
    check("async_rst_ready", bus.ready, 1);
    check("async_rst_period_start", period_start, 0);
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    model_advance();
    steps(30);

    // Randomized offers, enable drops and dead-time changes
    drop_left = 0;
    for (int n = 0; n < 1500; n++) begin
      if (drop_left > 0) begin
        drv_en = 0; drop_left--;
      end else if ($urandom_range(0, 39) == 0) begin
        drv_en = 0; drv_dt = $urandom_range(0, 4); drop_left = $urandom_range(0, 2);
      end else begin
        drv_en = 1;
      end
      drv_valid = ($urandom_range(0, 5) == 0);
      drv_p = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 10);
      for (int c = 0; c < NC; c++) drv_d[c] = $urandom_range(0, drv_p + 2);
      step();
    end
    drv_valid = 0;
    steps(2);
    @(negedge clk); #1;
    check("scoreboard_drained", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
